// File: rtl/zstd_stream_arbiter_if.sv
// rtl/zstd_stream_arbiter_if.sv - requester/consumer signal bundle for zstd_stream_arbiter
interface zstd_stream_arbiter_if #(
  parameter int Width     = 32,
  parameter int NumInputs = 4
);
  localparam int IdWidth = $clog2(NumInputs);

  logic [NumInputs*Width-1:0] in_data;
  logic [NumInputs-1:0]       in_valid;
  logic [NumInputs-1:0]       in_last;
  logic [NumInputs-1:0]       in_ready;
  logic [Width-1:0]           out_data;
  logic                       out_last;
  logic [IdWidth-1:0]         out_id;
  logic                       out_valid;
  logic                       out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_id, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_id, out_valid
  );
endinterface

// File: rtl/zstd_stream_arbiter.sv
// rtl/zstd_stream_arbiter.sv - round-robin N-to-1 stream arbiter into a single-entry output buffer
// Optional whole-packet grant lock: define ZSTD_ARB_PACKET_LOCK_EN
module zstd_stream_arbiter #(
  parameter int Width     = 32,
  parameter int NumInputs = 4
) (
  input logic                  clk,
  input logic                  rst,
  zstd_stream_arbiter_if.slave bus
);
  localparam int IdWidth = $clog2(NumInputs);
  localparam logic [IdWidth-1:0] LastId = IdWidth'(NumInputs - 1);

  logic               full_q, full_d;
  logic [Width-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [IdWidth-1:0] ptr_q, ptr_d;

  logic               can_accept;
  logic               rr_found;
  logic [IdWidth-1:0] rr_id;
  logic [IdWidth:0]   sum;
  logic               cand_found;
  logic [IdWidth-1:0] cand_id;
  logic [IdWidth-1:0] cand_next;
  logic               accept;
  logic               ptr_adv;
  logic               force_lock;
  logic [IdWidth-1:0] lock_id;
  logic [Width-1:0]   sel_data;
  logic               sel_last;

  assign can_accept = !full_q || bus.out_ready;

  // First valid requester at or after ptr, wrapping modulo NumInputs
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    sum      = '0;
    for (int k = 0; k < NumInputs; k++) begin
      sum = {1'b0, ptr_q} + (IdWidth+1)'(k);
      if (sum >= (IdWidth+1)'(NumInputs)) begin
        sum = sum - (IdWidth+1)'(NumInputs);
      end
      if (!rr_found && bus.in_valid[sum[IdWidth-1:0]]) begin
        rr_found = 1'b1;
        rr_id    = sum[IdWidth-1:0];
      end
    end
  end

  assign cand_found = force_lock ? bus.in_valid[lock_id] : rr_found;
  assign cand_id    = force_lock ? lock_id : rr_id;
  assign accept     = cand_found && can_accept && !rst;
  assign cand_next  = (cand_id == LastId) ? '0 : cand_id + IdWidth'(1);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NumInputs; k++) begin
      if (cand_id == IdWidth'(k)) begin
        sel_data = bus.in_data[k*Width +: Width];
        sel_last = bus.in_last[k];
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (accept) begin
      bus.in_ready[cand_id] = 1'b1;
    end
  end

`ifdef ZSTD_ARB_PACKET_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IdWidth-1:0] lock_id_q, lock_id_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: begin
        if (accept && !sel_last) begin
          state_d   = LOCKED;
          lock_id_d = cand_id;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer only moves when a packet closes, so a locked packet resumes RR after its owner
  always_comb begin
    force_lock = (state_q == LOCKED);
    lock_id    = lock_id_q;
    ptr_adv    = accept && sel_last;
  end
`else
  assign force_lock = 1'b0;
  assign lock_id    = '0;
  assign ptr_adv    = accept;
`endif

  // Drain and refill in the same cycle keeps full set
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    last_d = last_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = sel_data;
      last_d = sel_last;
      id_d   = cand_id;
    end else if (bus.out_ready) begin
      full_d = 1'b0;
    end
    if (ptr_adv) begin
      ptr_d = cand_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      id_q   <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      last_q <= last_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
    end
  end

  assign bus.out_valid = full_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_id    = id_q;
endmodule

// File: tb/tb_zstd_stream_arbiter.sv
// tb/tb_zstd_stream_arbiter.sv - scoreboard bench for zstd_stream_arbiter
module tb_zstd_stream_arbiter;
  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [31:0] src_data [4][8];
  logic        src_last [4][8];
  int          src_gap  [4][8];
  int          src_len  [4];
  int          src_pos  [4];
  int          gap_cnt  [4];
  logic [3:0]  acc;

  zstd_stream_arbiter_if #(.Width(32), .NumInputs(4)) bus ();

  zstd_stream_arbiter #(.Width(32), .NumInputs(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int i, input int b);
    return 32'hD000_0000 + 32'(i << 8) + 32'(b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [31:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    e.id   = 2'(i);
    exp_q.push_back(e);
  endtask

  task automatic add_beat(input int i, input logic [31:0] d, input logic l, input int g);
    src_data[i][src_len[i]] = d;
    src_last[i][src_len[i]] = l;
    src_gap[i][src_len[i]]  = g;
    if (src_pos[i] == src_len[i]) gap_cnt[i] = g;
    src_len[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
      gap_cnt[i] = 0;
    end
    acc = '0;
  endtask

  // Retire accepted beats and present the next head of each source
  task automatic drive_step();
    logic [3:0]   v;
    logic [3:0]   l;
    logic [127:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && src_pos[i] < src_len[i]) begin
        src_pos[i]++;
        gap_cnt[i] = (src_pos[i] < src_len[i]) ? src_gap[i][src_pos[i]] : 0;
      end
      if (src_pos[i] < src_len[i]) begin
        if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
        end else begin
          v[i] = 1'b1;
          l[i] = src_last[i][src_pos[i]];
          d[i*32 +: 32] = src_data[i][src_pos[i]];
        end
      end
    end
    acc = '0;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
  endtask

  task automatic tick();
    @(negedge clk);
    acc = rst ? 4'b0000 : (bus.in_valid & bus.in_ready);
    @(posedge clk);
    #1;
    drive_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_src();
    drive_step();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 40; n++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: got id=%0d data=%h, required no beat", bus.out_id, bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.out_data !== mon_e.data || bus.out_last !== mon_e.last || bus.out_id !== mon_e.id) begin
          failures++;
          $display("FAIL sb_beat: got id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                   bus.out_id, bus.out_data, bus.out_last, mon_e.id, mon_e.data, mon_e.last);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    bus.out_ready = 1'b1;
    rst = 1'b1;
    clear_src();
    #1;
    // Reset then idle
    add_beat(0, mk(0, 9), 1'b1, 0);
    drive_step();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_out_valid", 32'(bus.out_valid), 32'h0);
      chk("idle_in_ready", 32'(bus.in_ready), 32'h0);
      chk("idle_out_data", bus.out_data, 32'h0);
    end

    // Fairness: all four valid, single-beat packets
    do_reset();
    bus.out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        add_beat(i, mk(i, b), 1'b1, 0);
        push_exp(i, mk(i, b), 1'b1);
      end
    end
    drive_step();
    #1;
    wait_valid("fair_start");
    for (int k = 0; k < 8; k++) begin
      chk("fair_throughput", 32'(bus.out_valid), 32'h1);
      tick();
    end
    wait_drain("fair_drain");

    // Backpressure
    bus.out_ready = 1'b0;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      add_beat(2, mk(2, b), 1'b1, 0);
      push_exp(2, mk(2, b), 1'b1);
    end
    drive_step();
    #1;
    wait_valid("bp_start");
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_out_data", bus.out_data, mk(2, 0));
      chk("bp_out_id", 32'(bus.out_id), 32'd2);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_next_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_next_data", bus.out_data, mk(2, 1));
    wait_drain("bp_drain");

    // Input 1 sends a 3-beat packet with a gap, input 2 always valid
    bus.out_ready = 1'b1;
    do_reset();
    add_beat(1, mk(1, 0), 1'b0, 0);
    add_beat(1, mk(1, 1), 1'b0, 2);
    add_beat(1, mk(1, 2), 1'b1, 0);
    for (int b = 0; b < 3; b++) add_beat(2, mk(2, b), 1'b1, 0);
`ifdef ZSTD_ARB_PACKET_LOCK_EN
    push_exp(1, mk(1, 0), 1'b0);
    push_exp(1, mk(1, 1), 1'b0);
    push_exp(1, mk(1, 2), 1'b1);
    push_exp(2, mk(2, 0), 1'b1);
    push_exp(2, mk(2, 1), 1'b1);
    push_exp(2, mk(2, 2), 1'b1);
`else
    push_exp(1, mk(1, 0), 1'b0);
    push_exp(2, mk(2, 0), 1'b1);
    push_exp(2, mk(2, 1), 1'b1);
    push_exp(1, mk(1, 1), 1'b0);
    push_exp(2, mk(2, 2), 1'b1);
    push_exp(1, mk(1, 2), 1'b1);
`endif
    drive_step();
    #1;
    wait_valid("pkt_start");
    for (int k = 0; k < 2; k++) begin
`ifdef ZSTD_ARB_PACKET_LOCK_EN
      chk("pkt_gap_in_ready", 32'(bus.in_ready), 32'h0);
`else
      chk("pkt_gap_in_ready", 32'(bus.in_ready), 32'h4);
`endif
      tick();
    end
    wait_drain("pkt_drain");

    // Asynchronous reset with the buffer full mid-packet
    bus.out_ready = 1'b0;
    do_reset();
    add_beat(3, mk(3, 0), 1'b0, 0);
    add_beat(3, mk(3, 1), 1'b1, 0);
    drive_step();
    #1;
    wait_valid("arst_full");
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h0);
    clear_src();
    drive_step();
    tick();
    tick();
    rst = 1'b0;
    add_beat(0, mk(0, 5), 1'b1, 0);
    add_beat(3, mk(3, 5), 1'b1, 0);
    push_exp(0, mk(0, 5), 1'b1);
    push_exp(3, mk(3, 5), 1'b1);
    bus.out_ready = 1'b1;
    drive_step();
    #1;
    wait_drain("arst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/zstd_stream_arbiter.md
# zstd_stream_arbiter

Round-robin N-to-1 stream arbiter that multiplexes several ready/valid producers onto one shared single-entry output buffer. It sits in front of a shared zstd resource, such as a shared history-buffer write port or a shared FIFO, and sequences access between requesters. Each accepted beat is tagged with the index of the requester that sent it. With packet lock enabled, a granted requester keeps the grant until its `last` beat.

## Interface
- `Width`, 32, data width per beat.
- `NumInputs`, 4, number of requesters; must be ≥ 2.
- `IdWidth`, `$clog2(NumInputs)`, localparam, width of the requester index.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  NumInputs*Width  requester i occupies bits [i*Width +: Width].
- `in_valid`  in  NumInputs  per-requester valid.
- `in_last`  in  NumInputs  per-requester end-of-packet marker.
- `in_ready`  out  NumInputs  per-requester ready; at most one bit is high in any cycle.
- `out_data`  out  Width  buffered beat.
- `out_last`  out  1  `last` flag of the buffered beat.
- `out_id`  out  IdWidth  index of the requester that sent the buffered beat.
- `out_valid`  out  1  the buffer holds a beat.
- `out_ready`  in  1  the consumer accepts the buffered beat.

## Operation
- Output buffer: one register stage with a `full` flag.
  - `out_valid = full`.
  - `can_accept = !full || out_ready`. The buffer refills in the same cycle it drains, so throughput is 1 beat/cycle.
- Round-robin pointer `ptr` (IdWidth bits). The candidate is the first i with `in_valid[i]` high, searching `ptr, ptr+1, …` with wrap modulo NumInputs.
- Grant: `in_ready[cand] = can_accept`, and every other `in_ready` bit is 0.
  - `in_ready` may depend combinationally on any `in_valid` and on `out_ready`.
  - Requesters must not make `valid` depend on `ready`.
- Accept of requester i, i.e. `in_valid[i] && in_ready[i]`:
  - buffer loads `in_data[i]`, `in_last[i]` and `out_id = i`;
  - `full <= 1`.
- Drain without accept (`full && out_ready`, no accept): `full <= 0`. Output data registers hold their last value.
- Pointer update after an accept from requester i, when not in a locked packet: `ptr <= (i == NumInputs-1) ? 0 : i+1`.
- State machine (packet lock build only):
  - IDLE: arbitrate as above. An accept with `in_last[i] = 0` moves to LOCKED, `lock_id <= i`, and `ptr` is not updated. An accept with `in_last[i] = 1` stays in IDLE and updates `ptr`.
  - LOCKED: the candidate is forced to `lock_id`, and other valids are ignored. An accept with `last = 1` moves to IDLE with `ptr <= lock_id+1` (wrapped). A non-last accept stays in LOCKED.
  - While `in_valid[lock_id]` is deasserted, the arbiter stalls and no other requester is granted.
- Reset mid-packet clears the lock. Any beat still in the buffer is discarded.

## Timing
- Reset values: `full=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `out_id=0`, `ptr=0`, state IDLE. `in_ready` is all-zero while `rst` is high.
- Latency: 1 cycle. A beat accepted at edge k is on `out_*` with `out_valid=1` after edge k.
- Sustained: 1 beat/cycle when `out_ready` is held high.
- Backpressure: when `full && !out_ready`, every `in_ready` bit is 0. `out_*` stays stable until the beat is taken.
- Simultaneous drain and accept in one cycle: `full` stays 1 and the new beat replaces the old one.
- The pointer moves only on an accept. An idle cycle or a stall leaves `ptr` unchanged.

## Configuration
- `ZSTD_ARB_PACKET_LOCK_EN` defined: the IDLE/LOCKED state machine is present and grants last a whole packet, terminated by `in_last`.
- Not defined:
  - arbitration is per beat, with `ptr` advancing after every accept;
  - there is no lock state;
  - `in_last` is only forwarded to `out_last`.

## Test plan
- Reset then idle: hold `rst` high, then release with all valids low. Required: `out_valid=0`, `in_ready=0000`, `out_data=0` for 10 cycles.
- Fairness: all 4 inputs valid, single-beat packets (`last=1`), `out_ready=1`. Required: `out_id` sequence 0,1,2,3,0,1,… with one beat per cycle.
- Backpressure: buffer full and `out_ready=0` for 5 cycles. Required: `in_ready=0000`, `out_data` and `out_id` stable. Then `out_ready=1`: the next beat appears 1 cycle later.
- Packet lock (macro defined): input 1 sends a 3-beat packet with a 2-cycle valid gap after beat 1, while input 2 is valid throughout. Required: `out_id` reads 1,1,1 before any 2, and `in_ready[2]` stays 0 during the gap.
- Per-beat mode (macro undefined): same stimulus as the packet-lock test. Required: input 2 is granted during input 1's gap, and after each accept the pointer advances to the next index.
- Async reset while LOCKED with the buffer full: assert `rst` mid-cycle. Required: `out_valid` drops without waiting for a clock edge. After release, input 0 wins when inputs 0 and 3 are both valid.
